// File: rtl/audio_sample_scheduler.sv
// Audio pacing for the HDMI datapath: a fractional accumulator derives clk_audio
// and a sample strobe from clk_pixel, draining a stereo FIFO once per audio period.
module audio_sample_scheduler #(
  parameter int unsigned CLK_HZ        = 74250000,
  parameter int unsigned AUDIO_RATE    = 48000,
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter bit          UNDERRUN_ZERO = 1'b0
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear_stats,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_WIDTH-1:0]       in_left,
  input  logic [SAMPLE_WIDTH-1:0]       in_right,
  output logic                          clk_audio,
  output logic                          sample_strobe,
  output logic [SAMPLE_WIDTH-1:0]       audio_left,
  output logic [SAMPLE_WIDTH-1:0]       audio_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun_flag,
  output logic [15:0]                   underrun_count
);

  localparam int unsigned INC   = 2 * AUDIO_RATE;
  localparam int unsigned ACC_W = $clog2(CLK_HZ + INC);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned WORD_W = 2 * SAMPLE_WIDTH;

  localparam logic [ACC_W:0]  INC_EXT   = (ACC_W + 1)'(INC);
  localparam logic [ACC_W:0]  CLK_EXT   = (ACC_W + 1)'(CLK_HZ);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W:0]          acc_sum;
  logic                    tick;
  logic                    falling_tick;
  logic                    clk_audio_q, clk_audio_d;
  logic                    strobe_q, strobe_d;

  logic [WORD_W-1:0]       mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    underrun;
  logic [WORD_W-1:0]       head;

  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic [WORD_W-1:0]       last_q, last_d;
  logic                    flag_q, flag_d;
  logic [15:0]             count_q, count_d;

  // Wide sum keeps the compare exact; the remainder carries over so the average has no drift.
  always_comb begin
    acc_sum     = {1'b0, acc_q} + INC_EXT;
    acc_d       = acc_q;
    tick        = 1'b0;
    clk_audio_d = clk_audio_q;
    if (enable) begin
      if (acc_sum >= CLK_EXT) begin
        tick  = 1'b1;
        acc_d = ACC_W'(acc_sum - CLK_EXT);
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
    if (tick) begin
      clk_audio_d = ~clk_audio_q;
    end
  end

  assign falling_tick = tick && clk_audio_q;
  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign in_ready     = !full && !reset;
  assign push         = in_valid && in_ready;
  assign pop          = falling_tick && !empty;
  assign underrun     = falling_tick && empty;
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_left, in_right};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Samples move only on the falling tick, half a period ahead of the hdmi capture edge.
  always_comb begin
    strobe_d = falling_tick;
    left_d   = left_q;
    right_d  = right_q;
    last_d   = last_q;
    if (pop) begin
      left_d  = head[WORD_W-1:SAMPLE_WIDTH];
      right_d = head[SAMPLE_WIDTH-1:0];
      last_d  = head;
    end else if (underrun) begin
      if (UNDERRUN_ZERO) begin
        left_d  = '0;
        right_d = '0;
      end else begin
        left_d  = last_q[WORD_W-1:SAMPLE_WIDTH];
        right_d = last_q[SAMPLE_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    flag_d  = flag_q;
    count_d = count_q;
    if (clear_stats) begin
      flag_d  = 1'b0;
      count_d = '0;
    end else if (underrun) begin
      flag_d = 1'b1;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc_q       <= '0;
      clk_audio_q <= 1'b0;
      strobe_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      last_q      <= '0;
      flag_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      acc_q       <= acc_d;
      clk_audio_q <= clk_audio_d;
      strobe_q    <= strobe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      left_q      <= left_d;
      right_q     <= right_d;
      last_q      <= last_d;
      flag_q      <= flag_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: the pointers and level decide what is valid.
  always_ff @(posedge clk_pixel) begin
    mem_q <= mem_d;
  end

  assign clk_audio      = clk_audio_q;
  assign sample_strobe  = strobe_q;
  assign audio_left     = left_q;
  assign audio_right    = right_q;
  assign fifo_level     = level_q;
  assign underrun_flag  = flag_q;
  assign underrun_count = count_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: an exact-ratio instance (100/10, depth 4, hold)
// and a fractional instance (25/2, depth 2, zero-on-underrun).
module tb_audio_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, clear_stats, in_valid;
  logic [15:0] in_left, in_right;
  logic        in_ready, clk_audio, sample_strobe, underrun_flag;
  logic [15:0] audio_left, audio_right, underrun_count;
  logic [2:0]  fifo_level;

  logic        f_reset, f_enable, f_clear, f_valid;
  logic [15:0] f_left, f_right;
  logic        f_in_ready, f_clk_audio, f_strobe, f_flag;
  logic [15:0] f_audio_left, f_audio_right, f_count;
  logic [1:0]  f_level;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    int          acc_cyc;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  typedef struct {
    logic        valid;
    logic [15:0] left;
    logic [15:0] right;
    int          exp_level;
    logic        exp_ready;
  } vec_t;
  vec_t vecs[6];

  audio_sample_scheduler #(
    .CLK_HZ(100), .AUDIO_RATE(10), .SAMPLE_WIDTH(16), .FIFO_DEPTH(4), .UNDERRUN_ZERO(1'b0)
  ) dut (
    .clk_pixel(clk), .reset(reset), .enable(enable), .clear_stats(clear_stats),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .clk_audio(clk_audio), .sample_strobe(sample_strobe),
    .audio_left(audio_left), .audio_right(audio_right), .fifo_level(fifo_level),
    .underrun_flag(underrun_flag), .underrun_count(underrun_count)
  );

  audio_sample_scheduler #(
    .CLK_HZ(25), .AUDIO_RATE(2), .SAMPLE_WIDTH(16), .FIFO_DEPTH(2), .UNDERRUN_ZERO(1'b1)
  ) dut_f (
    .clk_pixel(clk), .reset(f_reset), .enable(f_enable), .clear_stats(f_clear),
    .in_valid(f_valid), .in_ready(f_in_ready), .in_left(f_left), .in_right(f_right),
    .clk_audio(f_clk_audio), .sample_strobe(f_strobe),
    .audio_left(f_audio_left), .audio_right(f_audio_right), .fifo_level(f_level),
    .underrun_flag(f_flag), .underrun_count(f_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Scoreboard: an accepted sample may be popped only at a strobe edge later than its push edge.
  initial begin : scoreboard
    sb_entry_t   e;
    logic [15:0] m_last_l, m_last_r, exp_l, exp_r;
    int          m_cnt;
    logic        m_flag, clr_pend;
    m_last_l = '0; m_last_r = '0; m_cnt = 0; m_flag = 1'b0; clr_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_pend) begin
        m_cnt  = 0;
        m_flag = 1'b0;
      end
      if (sample_strobe === 1'b1) begin
        if (sb_q.size() > 0 && sb_q[0].acc_cyc < cyc) begin
          e = sb_q.pop_front();
          m_last_l = e.left;
          m_last_r = e.right;
        end else if (!clr_pend) begin
          if (m_cnt < 65535) m_cnt++;
          m_flag = 1'b1;
        end
        exp_l = m_last_l;
        exp_r = m_last_r;
        checkOutput($sformatf("sb_left_c%0d", cyc), 32'(audio_left), 32'(exp_l));
        checkOutput($sformatf("sb_right_c%0d", cyc), 32'(audio_right), 32'(exp_r));
        checkOutput($sformatf("sb_level_c%0d", cyc), 32'(fifo_level), 32'(sb_q.size()));
        checkOutput($sformatf("sb_ucount_c%0d", cyc), 32'(underrun_count), 32'(m_cnt));
        checkOutput($sformatf("sb_uflag_c%0d", cyc), 32'(underrun_flag), 32'(m_flag));
      end
      clr_pend = clear_stats;
      if (reset) begin
        sb_q.delete();
        m_last_l = '0; m_last_r = '0; m_cnt = 0; m_flag = 1'b0; clr_pend = 1'b0;
      end else if (in_valid && in_ready) begin
        e.left    = in_left;
        e.right   = in_right;
        e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input vec_t v);
    in_valid = v.valid;
    in_left  = v.left;
    in_right = v.right;
    @(posedge clk); #2;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic push_one(input logic [15:0] l, input logic [15:0] r);
    bit ok = 1'b0;
    in_valid = 1'b1; in_left = l; in_right = r;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    checkOutput($sformatf("push_%0h", l), 32'(ok), 32'd1);
  endtask

  task automatic wait_f_strobe(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (f_strobe) begin found = 1'b1; break; end
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  // Enable must already be set; called at posedge+2.
  task automatic pace_check(input string tag);
    int strobes = 0;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_rst_clk"}, 32'(clk_audio), 32'd0);
    checkOutput({tag, "_rst_strobe"}, 32'(sample_strobe), 32'd0);
    checkOutput({tag, "_rst_left"}, 32'(audio_left), 32'd0);
    checkOutput({tag, "_rst_right"}, 32'(audio_right), 32'd0);
    checkOutput({tag, "_rst_level"}, 32'(fifo_level), 32'd0);
    checkOutput({tag, "_rst_flag"}, 32'(underrun_flag), 32'd0);
    checkOutput({tag, "_rst_count"}, 32'(underrun_count), 32'd0);
    checkOutput({tag, "_rst_ready"}, 32'(in_ready), 32'd1);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (sample_strobe) strobes++;
      if (k <= 12) begin
        checkOutput($sformatf("%s_clk_e%0d", tag, k), 32'(clk_audio), 32'(((k / 5) % 2) == 1));
        checkOutput($sformatf("%s_strobe_e%0d", tag, k), 32'(sample_strobe), 32'((k % 10) == 0));
      end
    end
    checkOutput({tag, "_strobes_100"}, 32'(strobes), 32'd10);
    checkOutput({tag, "_ucount_100"}, 32'(underrun_count), 32'd10);
    checkOutput({tag, "_uflag_100"}, 32'(underrun_flag), 32'd1);
  endtask

  initial begin
    int   en1, toggles, strobes;
    logic prev;
    vecs[0] = '{1'b1, 16'h1111, 16'hAAAA, 1, 1'b1};
    vecs[1] = '{1'b1, 16'h2222, 16'hBBBB, 2, 1'b1};
    vecs[2] = '{1'b1, 16'h3333, 16'hCCCC, 3, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 3, 1'b1};
    vecs[4] = '{1'b1, 16'h4444, 16'hDDDD, 4, 1'b0};
    vecs[5] = '{1'b1, 16'h5555, 16'hEEEE, 4, 1'b0};

    reset = 1'b1; enable = 1'b0; clear_stats = 1'b0; in_valid = 1'b0;
    in_left = '0; in_right = '0;
    f_reset = 1'b1; f_enable = 1'b1; f_clear = 1'b0; f_valid = 1'b0;
    f_left = '0; f_right = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_clk", 32'(clk_audio), 32'd0);
    checkOutput("reset_strobe", 32'(sample_strobe), 32'd0);
    checkOutput("reset_left", 32'(audio_left), 32'd0);
    checkOutput("reset_level", 32'(fifo_level), 32'd0);
    checkOutput("reset_count", 32'(underrun_count), 32'd0);

    // Fractional pacing: any 25 enabled cycles advance acc by exactly 100 = 4 * CLK_HZ.
    f_reset = 1'b0;
    @(negedge clk);
    prev = f_clk_audio;
    for (int w = 0; w < 10; w++) begin
      toggles = 0; strobes = 0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (f_clk_audio != prev) toggles++;
        prev = f_clk_audio;
        if (f_strobe) strobes++;
      end
      checkOutput($sformatf("f_toggles_w%0d", w), 32'(toggles), 32'd4);
      checkOutput($sformatf("f_strobes_w%0d", w), 32'(strobes), 32'd2);
    end
    wait_f_strobe("f_strobe_a");
    @(posedge clk); #2;
    f_valid = 1'b1; f_left = 16'h1234; f_right = 16'h5678;
    @(negedge clk);
    checkOutput("f_ready", 32'(f_in_ready), 32'd1);
    @(posedge clk); #2;
    f_valid = 1'b0;
    wait_f_strobe("f_strobe_b");
    checkOutput("f_pop_left", 32'(f_audio_left), 32'h1234);
    checkOutput("f_pop_right", 32'(f_audio_right), 32'h5678);
    wait_f_strobe("f_strobe_c");
    checkOutput("f_zero_left", 32'(f_audio_left), 32'h0);
    checkOutput("f_zero_right", 32'(f_audio_right), 32'h0);
    checkOutput("f_zero_count", 32'(f_count), 32'd22);

    // Exact pacing from reset with an empty FIFO, then a standalone clear.
    @(posedge clk); #2;
    enable = 1'b1;
    pace_check("pace");
    @(posedge clk); #2;
    clear_stats = 1'b1;
    @(posedge clk); #2;
    clear_stats = 1'b0;
    checkOutput("clear_count", 32'(underrun_count), 32'd0);
    checkOutput("clear_flag", 32'(underrun_flag), 32'd0);

    // Backpressure table with pacing frozen.
    enable = 1'b0;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
    end
    enable = 1'b1;
    en1 = cyc + 1;
    step_to(en1 + 8);
    checkOutput("bp_e9_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_e9_level", 32'(fifo_level), 32'd4);
    step_to(en1 + 9);
    checkOutput("bp_e10_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_e10_level", 32'(fifo_level), 32'd3);
    checkOutput("bp_e10_left", 32'(audio_left), 32'h1111);
    step_to(en1 + 10);
    in_valid = 1'b0;
    checkOutput("bp_e11_level", 32'(fifo_level), 32'd4);
    checkOutput("bp_e11_ready", 32'(in_ready), 32'd0);

    // Two held-sample underruns, then a clear on the same edge as a third underrun.
    step_to(en1 + 69);
    checkOutput("hold_left", 32'(audio_left), 32'h5555);
    checkOutput("hold_right", 32'(audio_right), 32'hEEEE);
    checkOutput("hold_count", 32'(underrun_count), 32'd2);
    checkOutput("hold_flag", 32'(underrun_flag), 32'd1);
    step_to(en1 + 78);
    clear_stats = 1'b1;
    step_to(en1 + 79);
    clear_stats = 1'b0;
    checkOutput("clr_prio_strobe", 32'(sample_strobe), 32'd1);
    checkOutput("clr_prio_count", 32'(underrun_count), 32'd0);
    checkOutput("clr_prio_flag", 32'(underrun_flag), 32'd0);

    // Reset mid-stream with three samples queued and clk_audio high.
    push_one(16'h6666, 16'h0101);
    push_one(16'h7777, 16'h0202);
    push_one(16'h8888, 16'h0303);
    step_to(en1 + 84);
    checkOutput("mid_clk_high", 32'(clk_audio), 32'd1);
    checkOutput("mid_level3", 32'(fifo_level), 32'd3);
    pace_check("mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
